dmem_store_buf: RTL and testbench

Store-side companion to the data-memory load path: accepts store requests (SB/SH/SW) from the execute stage, converts them into byte-lane-aligned, byte-enabled word writes, and buffers them in a small FIFO that drains into data memory under a grant handshake. Also flags read-after-write hazards so the pipeline stalls a load that targets a word with a pending store.

---
 rtl/dmem_store_buf_pkg.sv | 14 +
 rtl/dmem_store_buf_if.sv | 34 +++
 rtl/dmem_store_buf_sb_fifo.sv | 82 ++++++++
 rtl/dmem_store_buf.sv | 98 +++++++++
 tb/tb_dmem_store_buf.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_store_buf_pkg.sv
// Shared store-width encodings and the pre-formatted lane payload used by the store buffer.
package dmem_store_buf_pkg;

  localparam logic [2:0] FUNC3_SB = 3'b000;
  localparam logic [2:0] FUNC3_SH = 3'b001;
  localparam logic [2:0] FUNC3_SW = 3'b010;

  // Byte enables plus lane-replicated data, exactly as presented to data memory.
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } lane_t;

endpackage

// File: rtl/dmem_store_buf_if.sv
// Store request, memory write and load-hazard signals between pipeline/memory and the store buffer.
interface dmem_store_buf_if #(
  parameter int unsigned AW = 11
);

  logic          st_valid;
  logic          st_ready;
  logic [2:0]    st_funct3;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          st_err;

  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          empty;

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_gnt, ld_valid, ld_addr,
    input  st_ready, st_err, mem_we, mem_addr, mem_be, mem_wdata, ld_hazard, empty
  );

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_gnt, ld_valid, ld_addr,
    output st_ready, st_err, mem_we, mem_addr, mem_be, mem_wdata, ld_hazard, empty
  );

endinterface

// File: rtl/dmem_store_buf_sb_fifo.sv
// FIFO of pre-formatted word writes with per-entry word-address compare for load hazards.
module sb_fifo
  import dmem_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WAW   = 9
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WAW-1:0]   push_addr,
  input  lane_t            push_lane,
  input  logic             pop,
  output logic             head_valid,
  output logic [WAW-1:0]   head_addr,
  output lane_t            head_lane,
  output logic             full,
  output logic             empty,
  input  logic [WAW-1:0]   cmp_addr,
  output logic [DEPTH-1:0] hit
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [WAW-1:0] addr_q [DEPTH];
  lane_t          lane_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic do_push;
  logic do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && vld_q[rd_ptr];

  // Push and pop never touch the same slot: a push into the head slot implies the FIFO was empty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        lane_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        addr_q[wr_ptr] <= push_addr;
        lane_q[wr_ptr] <= push_lane;
        vld_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_valid = vld_q[rd_ptr];
  assign head_addr  = head_valid ? addr_q[rd_ptr] : '0;
  assign head_lane  = head_valid ? lane_q[rd_ptr] : '0;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit[i] = vld_q[i] && (addr_q[i] == cmp_addr);
    end
  end

endmodule

// File: rtl/dmem_store_buf.sv
// Store buffer: checks store legality, formats byte lanes, queues writes and flags load hazards.
module dmem_store_buf
  import dmem_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 11
) (
  input  logic             clk,
  input  logic             nrst,
  dmem_store_buf_if.slave  bus
);

  localparam int unsigned WAW = AW - 2;

  logic             legal;
  lane_t            lane;
  logic             accept;
  logic             push;
  logic             st_err_q;
  logic             full;
  logic             fifo_empty;
  logic             head_valid;
  logic [WAW-1:0]   head_addr;
  lane_t            head_lane;
  logic [DEPTH-1:0] hit;

  // Alignment check and lane placement, decoded from the offered store.
  always_comb begin
    legal = 1'b0;
    lane  = '0;
    case (bus.st_funct3)
      FUNC3_SB: begin
        legal      = 1'b1;
        lane.be    = 4'b0001 << bus.st_addr[1:0];
        lane.wdata = {4{bus.st_data[7:0]}};
      end
      FUNC3_SH: begin
        legal      = !bus.st_addr[0];
        lane.be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        lane.wdata = {2{bus.st_data[15:0]}};
      end
      FUNC3_SW: begin
        legal      = (bus.st_addr[1:0] == 2'b00);
        lane.be    = 4'b1111;
        lane.wdata = bus.st_data;
      end
      default: begin
        legal = 1'b0;
        lane  = '0;
      end
    endcase
  end

  assign accept = bus.st_valid && !full;
  assign push   = accept && legal;

  // A rejected store still completes the handshake; it only reports for one cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= accept && !legal;
    end
  end

  sb_fifo #(
    .DEPTH (DEPTH),
    .WAW   (WAW)
  ) u_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push       (push),
    .push_addr  (bus.st_addr[AW-1:2]),
    .push_lane  (lane),
    .pop        (bus.mem_gnt),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_lane  (head_lane),
    .full       (full),
    .empty      (fifo_empty),
    .cmp_addr   (bus.ld_addr[AW-1:2]),
    .hit        (hit)
  );

  assign bus.st_ready  = !full;
  assign bus.st_err    = st_err_q;
  assign bus.mem_we    = head_valid;
  assign bus.mem_addr  = head_addr;
  assign bus.mem_be    = head_lane.be;
  assign bus.mem_wdata = head_lane.wdata;
  assign bus.ld_hazard = bus.ld_valid && (|hit);
  assign bus.empty     = fifo_empty;

  // Address bits outside the data-memory window and the load byte offset play no part.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.st_addr[31:AW], bus.ld_addr[31:AW], bus.ld_addr[1:0]};

endmodule

// File: tb/tb_dmem_store_buf.sv
// Directed bench for dmem_store_buf: lane formatting, rejects, full/drain, hazards, reset, streaming.
module tb_dmem_store_buf;

  localparam int unsigned AW = 11;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_err;

  dmem_store_buf_if #(.AW(AW)) bus ();

  dmem_store_buf #(.DEPTH(4), .AW(AW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one store across a single rising edge, then withdraw it.
  task automatic offer(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid  = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr   = addr;
    bus.st_data   = data;
    tick();
    bus.st_valid  = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst          = 1'b0;
    bus.st_valid  = 1'b0;
    bus.st_funct3 = 3'b000;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.mem_gnt   = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;

    // Reset state
    #12;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_err", 32'(bus.st_err), 32'd0);
    chk("rst_hazard", 32'(bus.ld_hazard), 32'd0);
    nrst = 1'b1;

    // SB to lane 3, granted immediately
    bus.mem_gnt = 1'b1;
    offer(3'b000, 32'h003, 32'h0000_00A5);
    chk("sb3_we", 32'(bus.mem_we), 32'd1);
    chk("sb3_addr", 32'(bus.mem_addr), 32'd0);
    chk("sb3_be", 32'(bus.mem_be), 32'b1000);
    chk("sb3_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    chk("sb3_nempty", 32'(bus.empty), 32'd0);
    tick();
    chk("sb3_ret_empty", 32'(bus.empty), 32'd1);
    chk("sb3_ret_we", 32'(bus.mem_we), 32'd0);

    // SB to lane 1 and SH to both halves
    offer(3'b000, 32'h001, 32'hFFFF_FF5A);
    chk("sb1_be", 32'(bus.mem_be), 32'b0010);
    chk("sb1_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
    tick();
    bus.mem_gnt = 1'b0;
    offer(3'b001, 32'h006, 32'h0000_1234);
    chk("sh6_addr", 32'(bus.mem_addr), 32'd1);
    chk("sh6_be", 32'(bus.mem_be), 32'b1100);
    chk("sh6_wdata", bus.mem_wdata, 32'h1234_1234);
    chk("sh6_err", 32'(bus.st_err), 32'd0);
    tick();
    chk("sh6_hold_be", 32'(bus.mem_be), 32'b1100);
    bus.mem_gnt = 1'b1;
    tick();
    chk("sh6_ret_empty", 32'(bus.empty), 32'd1);
    offer(3'b001, 32'h008, 32'hABCD_5678);
    chk("sh8_addr", 32'(bus.mem_addr), 32'd2);
    chk("sh8_be", 32'(bus.mem_be), 32'b0011);
    chk("sh8_wdata", bus.mem_wdata, 32'h5678_5678);
    tick();

    // Rejected stores: misaligned SH, misaligned SW, illegal funct3
    offer(3'b001, 32'h005, 32'h0000_1234);
    chk("sh5_err", 32'(bus.st_err), 32'd1);
    chk("sh5_empty", 32'(bus.empty), 32'd1);
    chk("sh5_we", 32'(bus.mem_we), 32'd0);
    tick();
    chk("sh5_err_clr", 32'(bus.st_err), 32'd0);
    offer(3'b010, 32'h00E, 32'h1111_2222);
    chk("swmis_err", 32'(bus.st_err), 32'd1);
    chk("swmis_empty", 32'(bus.empty), 32'd1);
    offer(3'b011, 32'h010, 32'h1111_2222);
    chk("f3bad_err", 32'(bus.st_err), 32'd1);
    chk("f3bad_empty", 32'(bus.empty), 32'd1);
    tick();

    // Fill with gnt low, then drain in order
    bus.mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d_ready", k), 32'(bus.st_ready), 32'd1);
      offer(3'b010, 32'h100 + 32'(4 * k), 32'hD000_0000 + 32'(k));
    end
    chk("full_ready", 32'(bus.st_ready), 32'd0);
    chk("full_addr", 32'(bus.mem_addr), 32'h40);
    chk("full_be", 32'(bus.mem_be), 32'b1111);
    offer(3'b011, 32'h120, 32'h0);
    chk("full_noerr", 32'(bus.st_err), 32'd0);
    chk("full_still", 32'(bus.st_ready), 32'd0);
    chk("full_head", bus.mem_wdata, 32'hD000_0000);
    bus.mem_gnt = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("drain%0d_ready", k), 32'(bus.st_ready), 32'd1);
      chk($sformatf("drain%0d_wdata", k), bus.mem_wdata, 32'hD000_0000 + 32'(k));
      chk($sformatf("drain%0d_addr", k), 32'(bus.mem_addr), 32'h40 + 32'(k));
    end
    tick();
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Load hazard against a pending SW at 0x010
    bus.mem_gnt = 1'b0;
    offer(3'b010, 32'h010, 32'hCAFE_F00D);
    bus.ld_addr = 32'h013;
    #1;
    chk("haz_noval", 32'(bus.ld_hazard), 32'd0);
    bus.ld_valid = 1'b1;
    #1;
    chk("haz_same_word", 32'(bus.ld_hazard), 32'd1);
    bus.ld_addr = 32'h014;
    #1;
    chk("haz_next_word", 32'(bus.ld_hazard), 32'd0);
    bus.ld_addr = 32'h810;
    #1;
    chk("haz_alias_hi", 32'(bus.ld_hazard), 32'd1);
    bus.ld_addr = 32'h010;
    bus.mem_gnt = 1'b1;
    #1;
    chk("haz_retiring", 32'(bus.ld_hazard), 32'd1);
    tick();
    chk("haz_after_ret", 32'(bus.ld_hazard), 32'd0);
    bus.ld_valid = 1'b0;

    // Asynchronous reset in the middle of a drain
    bus.mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(3'b010, 32'h300 + 32'(4 * k), 32'hE000_0000 + 32'(k));
    end
    bus.mem_gnt = 1'b1;
    tick();
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_we", 32'(bus.mem_we), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_ready", 32'(bus.st_ready), 32'd1);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    #2;
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("arst_quiet%0d", k), 32'(bus.mem_we), 32'd0);
    end

    // Streaming: one push and one retire per cycle at occupancy two
    bus.mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(3'b010, 32'h200 + 32'(4 * k), 32'hC000_0000 + 32'(k));
      exp_q.push_back('{waddr: (32'h200 + 32'(4 * k)) >> 2, data: 32'hC000_0000 + 32'(k)});
    end
    bus.mem_gnt = 1'b1;
    for (int k = 2; k < 22; k++) begin
      bus.st_valid  = 1'b1;
      bus.st_funct3 = 3'b010;
      bus.st_addr   = 32'h200 + 32'(4 * k);
      bus.st_data   = 32'hC000_0000 + 32'(k);
      #1;
      chk($sformatf("strm%0d_we", k), 32'(bus.mem_we), 32'd1);
      chk($sformatf("strm%0d_wdata", k), bus.mem_wdata, exp_q[0].data);
      chk($sformatf("strm%0d_addr", k), 32'(bus.mem_addr), exp_q[0].waddr & 32'h1FF);
      chk($sformatf("strm%0d_ready", k), 32'(bus.st_ready), 32'd1);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back('{waddr: (32'h200 + 32'(4 * k)) >> 2, data: 32'hC000_0000 + 32'(k)});
    end
    bus.st_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tail%0d_wdata", k), bus.mem_wdata, exp_q[0].data);
      void'(exp_q.pop_front());
      tick();
    end
    chk("tail_empty", 32'(bus.empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
